// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Releases N_STAGES downstream reset domains one at a time, in index order.
//   A domain is released only after the previous one reports ready. Each
//   stage has a ready timeout, and any ready that drops later is treated as
//   a fault. sys_ready is raised once every domain is up. A fault is latched
//   together with the index of the offending stage, and every domain is put
//   back into reset.
//
//   Optional build macro: RESET_SEQ_RETRY_EN
//     When defined, the first two WAIT timeouts do not fault. Instead they
//     restart the whole HOLD/release sequence, and the third timeout faults.
//     Ready-drop faults never retry.
//     When undefined, the first timeout faults and no retry logic is built.
module reset_sequencer #(
  parameter int N_STAGES    = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int TIMEOUT     = 255
) (
  input  logic                clk,
  input  logic                sync_reset,
  input  logic                clk_enable,
  input  logic [N_STAGES-1:0] stage_ready,
  output logic [N_STAGES-1:0] stage_reset,
  output logic                sys_ready,
  output logic                fault,
  output logic [2:0]          fault_stage
);

  localparam int HW = $clog2(HOLD_CYCLES) + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;

  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [2:0]    LAST_IDX  = 3'(N_STAGES - 1);

  typedef enum logic [1:0] {
    S_HOLD,
    S_WAIT,
    S_RUN,
    S_FAULT
  } state_t;

  state_t        state;
  logic [HW-1:0] hold_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [2:0]    idx;
`ifdef RESET_SEQ_RETRY_EN
  logic [1:0]    retry_cnt;
`endif

  logic       cur_ready;
  logic       drop_below;
  logic [2:0] drop_idx;
  logic       any_low;
  logic [2:0] low_idx;

  // Reset mask in which stages 0..last stay released and all higher stages stay held.
  function automatic logic [N_STAGES-1:0] held_mask(input logic [2:0] last);
    logic [N_STAGES-1:0] m;
    for (int j = 0; j < N_STAGES; j++) begin
      m[j] = (3'(j) > last);
    end
    return m;
  endfunction

  // Decode the ready of the current stage and find the lowest low ready bit,
  // both among the released stages below idx and across all stages.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the loop leaves a value unassigned and no latch can be inferred.
    cur_ready  = 1'b0;
    drop_below = 1'b0;
    drop_idx   = 3'd0;
    any_low    = 1'b0;
    low_idx    = 3'd0;
    // The loop runs downward, so the last match it keeps is the lowest index.
    for (int j = N_STAGES - 1; j >= 0; j--) begin
      if (3'(j) == idx) cur_ready = stage_ready[j];
      if (!stage_ready[j]) begin
        any_low = 1'b1;
        low_idx = 3'(j);
        if (3'(j) < idx) begin
          drop_below = 1'b1;
          drop_idx   = 3'(j);
        end
      end
    end
  end

  // Sequencer FSM. All outputs are registered here.
  always_ff @(posedge clk) begin
    // NOTE: state is written with non-blocking assignments only. Every
    // right-hand side then sees the values from before this edge.
    if (sync_reset) begin
      state       <= S_HOLD;
      stage_reset <= '1;
      sys_ready   <= 1'b0;
      fault       <= 1'b0;
      fault_stage <= 3'd0;
      hold_cnt    <= '0;
      tmo_cnt     <= '0;
      idx         <= 3'd0;
`ifdef RESET_SEQ_RETRY_EN
      retry_cnt   <= 2'd0;
`endif
    end else begin
      case (state)
        S_HOLD: begin
          // Only enabled edges count toward the hold time.
          if (clk_enable) begin
            if (hold_cnt == HOLD_LAST) begin
              state       <= S_WAIT;
              idx         <= 3'd0;
              tmo_cnt     <= '0;
              stage_reset <= held_mask(3'd0);
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
        end

        S_WAIT: begin
          if (drop_below) begin
            // A stage that was already up has lost ready. This check
            // outranks both advancing and the timeout.
            state       <= S_FAULT;
            fault       <= 1'b1;
            fault_stage <= drop_idx;
            stage_reset <= '1;
            sys_ready   <= 1'b0;
          end else if (cur_ready) begin
            tmo_cnt <= '0;
            if (idx == LAST_IDX) begin
              state     <= S_RUN;
              sys_ready <= 1'b1;
            end else begin
              idx         <= idx + 3'd1;
              stage_reset <= held_mask(idx + 3'd1);
            end
          end else if (tmo_cnt == TMO_LAST) begin
`ifdef RESET_SEQ_RETRY_EN
            if (retry_cnt != 2'd2) begin
              // Re-hold every domain and run the whole sequence again.
              state       <= S_HOLD;
              hold_cnt    <= '0;
              tmo_cnt     <= '0;
              idx         <= 3'd0;
              stage_reset <= '1;
              retry_cnt   <= retry_cnt + 2'd1;
            end else begin
              state       <= S_FAULT;
              fault       <= 1'b1;
              fault_stage <= idx;
              stage_reset <= '1;
              sys_ready   <= 1'b0;
            end
`else
            state       <= S_FAULT;
            fault       <= 1'b1;
            fault_stage <= idx;
            stage_reset <= '1;
            sys_ready   <= 1'b0;
`endif
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        S_RUN: begin
          if (any_low) begin
            state       <= S_FAULT;
            fault       <= 1'b1;
            fault_stage <= low_idx;
            stage_reset <= '1;
            sys_ready   <= 1'b0;
          end
        end

        S_FAULT: begin
          // Sticky. Only sync_reset leaves this state.
        end

        default: begin
          state <= S_FAULT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer
//   Randomized bench for reset_sequencer with default parameters.
//   For each run it first picks the stimulus: clk_enable pattern, per-stage
//   ready latency, an optional one-cycle ready drop and an optional early
//   reset. It then works out from those choices, as a timeline of edge
//   numbers, when each stage is released, when sys_ready rises and when or
//   whether a fault occurs. Outputs are compared with that timeline on
//   every cycle.
module tb_reset_sequencer;

  localparam int NS    = 4;
  localparam int HC    = 16;
  localparam int TO    = 255;
  localparam int MAXT  = 4096;
  localparam int NEVER = 1 << 30;

  logic          clk = 1'b0;
  logic          sync_reset;
  logic          clk_enable;
  logic [NS-1:0] stage_ready;
  logic [NS-1:0] stage_reset;
  logic          sys_ready;
  logic          fault;
  logic [2:0]    fault_stage;

  int n_cmp = 0;
  int n_bad = 0;

  reset_sequencer #(
    .N_STAGES   (NS),
    .HOLD_CYCLES(HC),
    .TIMEOUT    (TO)
  ) dut (
    .clk        (clk),
    .sync_reset (sync_reset),
    .clk_enable (clk_enable),
    .stage_ready(stage_ready),
    .stage_reset(stage_reset),
    .sys_ready  (sys_ready),
    .fault      (fault),
    .fault_stage(fault_stage)
  );

  always #5 clk = ~clk;

  // Plan of the current run. Edge 1 is the first edge after the reset edge.
  bit            en[MAXT];
  int            lat[NS];       // ready is sampled high this many edges after release
  int            rel[NS];       // edge that releases each reached stage
  bit            reached[NS];
  int            hold_end;
  int            run_at;
  int            tmo_at;
  int            tmo_stage;
  int            fault_at;
  int            f_stage;
  int            td;            // edge at which the ready drop is sampled (0 = none)
  logic [NS-1:0] drop_mask;
  int            run_len;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int rand_lat();
    int r;
    r = int'($urandom_range(0, 9));
    if (r <= 6) return int'($urandom_range(1, 6));
    if (r == 7) return int'($urandom_range(250, 255));
    if (r == 8) return TO;
    return int'($urandom_range(256, 400));
  endfunction

  // Release edges follow from the hold length and the chained ready latencies.
  task automatic build_timeline();
    int cnt;
    int cur;
    cnt      = 0;
    hold_end = 0;
    for (int t = 1; t < MAXT; t++) begin
      if (en[t]) begin
        cnt++;
        if (cnt == HC) begin
          hold_end = t;
          break;
        end
      end
    end
    cur       = hold_end;
    run_at    = NEVER;
    tmo_at    = NEVER;
    tmo_stage = 0;
    for (int k = 0; k < NS; k++) reached[k] = 1'b0;
    for (int k = 0; k < NS; k++) begin
      reached[k] = 1'b1;
      rel[k]     = cur;
      if (lat[k] > TO) begin
        tmo_at    = cur + TO;
        tmo_stage = k;
        break;
      end
      cur += lat[k];
    end
    if (tmo_at == NEVER) run_at = cur;
  endtask

  // A drop affects only bits that were already up before the drop edge.
  // It wins over a timeout that falls on the same edge.
  task automatic resolve_fault();
    logic [NS-1:0] meff;
    meff      = '0;
    fault_at  = tmo_at;
    f_stage   = tmo_stage;
    if (td > 0) begin
      for (int j = 0; j < NS; j++) begin
        if (drop_mask[j] && reached[j] && (rel[j] + lat[j] < td)) meff[j] = 1'b1;
      end
    end
    if (meff != '0 && td <= tmo_at) begin
      fault_at = td;
      for (int j = NS - 1; j >= 0; j--) if (meff[j]) f_stage = j;
    end
  endtask

  function automatic logic [NS-1:0] ready_at(input int t);
    logic [NS-1:0] r;
    for (int j = 0; j < NS; j++) begin
      r[j] = reached[j] && (t >= rel[j] + lat[j]) &&
             !(t == td && drop_mask[j] && (rel[j] + lat[j] < td));
    end
    return r;
  endfunction

  task automatic make_plan(input int mode);
    int pat;
    int last;
    pat = (mode == 1) ? 1 : (mode >= 7) ? int'($urandom_range(0, 2)) : 0;
    for (int t = 0; t < MAXT; t++) begin
      case (pat)
        0:       en[t] = 1'b1;
        1:       en[t] = (t % 2 == 0);
        default: en[t] = 1'($urandom);
      endcase
    end
    for (int k = 0; k < NS; k++) lat[k] = (mode >= 7) ? rand_lat() : 3;
    if (mode == 1) for (int k = 0; k < NS; k++) lat[k] = int'($urandom_range(1, 5));
    if (mode == 2) lat[2] = 100000;
    if (mode == 3) begin
      lat[0] = 2; lat[1] = TO; lat[2] = 2; lat[3] = 2;
    end
    td        = 0;
    drop_mask = '0;
    build_timeline();
    if (mode == 4) begin
      td        = run_at + 3;
      drop_mask = 4'b1010;
    end
    if (mode >= 7 && $urandom_range(0, 1) == 1) begin
      last      = (tmo_at != NEVER) ? tmo_at : run_at + 4;
      td        = int'($urandom_range(1, last));
      drop_mask = NS'($urandom_range(1, (1 << NS) - 1));
    end
    resolve_fault();
    run_len = ((fault_at != NEVER) ? fault_at : run_at) + int'($urandom_range(2, 6));
    if (mode == 5) run_len = rel[2] + 2;
    if (mode >= 7 && $urandom_range(0, 3) == 0) run_len = int'($urandom_range(1, run_len));
  endtask

  task automatic do_run(input int run);
    logic [NS-1:0] exp_rst;
    logic          exp_rdy;
    logic          exp_flt;
    logic [2:0]    exp_fs;
    int            c;
    // Reset edge, with the other inputs random to show reset overrides them.
    @(negedge clk);
    sync_reset  = 1'b1;
    clk_enable  = 1'($urandom);
    stage_ready = NS'($urandom);
    @(negedge clk);
    check($sformatf("run%0d reset stage_reset", run), 32'(stage_reset), 32'({NS{1'b1}}));
    check($sformatf("run%0d reset sys_ready", run), 32'(sys_ready), 32'd0);
    check($sformatf("run%0d reset fault", run), 32'(fault), 32'd0);
    check($sformatf("run%0d reset fault_stage", run), 32'(fault_stage), 32'd0);
    for (int t = 1; t <= run_len; t++) begin
      sync_reset  = 1'b0;
      clk_enable  = en[t];
      stage_ready = ready_at(t);
      @(negedge clk);
      if (t >= fault_at) begin
        exp_rst = '1;
        exp_rdy = 1'b0;
        exp_flt = 1'b1;
        exp_fs  = 3'(f_stage);
      end else begin
        c = 0;
        for (int k = 0; k < NS; k++) if (reached[k] && rel[k] <= t) c = k + 1;
        for (int j = 0; j < NS; j++) exp_rst[j] = (j >= c);
        exp_rdy = (t >= run_at);
        exp_flt = 1'b0;
        exp_fs  = 3'd0;
      end
      check($sformatf("run%0d t%0d stage_reset", run, t), 32'(stage_reset), 32'(exp_rst));
      check($sformatf("run%0d t%0d sys_ready", run, t), 32'(sys_ready), 32'(exp_rdy));
      check($sformatf("run%0d t%0d fault", run, t), 32'(fault), 32'(exp_flt));
      check($sformatf("run%0d t%0d fault_stage", run, t), 32'(fault_stage), 32'(exp_fs));
    end
  endtask

  initial begin
    sync_reset  = 1'b1;
    clk_enable  = 1'b0;
    stage_ready = '0;
    // Runs 0..6 cover the named scenarios in order: nominal, toggling
    // enable, stage 2 never ready, ready on the last timeout cycle, ready
    // drop in RUN, reset in WAIT(2), then nominal after that reset.
    // The remaining runs are fully random.
    for (int run = 0; run < 48; run++) begin
      make_plan((run == 6) ? 0 : run);
      do_run(run);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
